sig_monitor: RTL and testbench



---
 rtl/sig_monitor.sv | 150 +++++++++++++++
 tb/tb_sig_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sig_monitor.sv
// Independent reader-side checker of the highway/country traffic light codes.
// Flags rule violations as registered pulses and latches the first one as a sticky fault.
module sig_monitor #(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned MIN_ALLRED = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    output logic       viol,
    output logic [2:0] viol_code,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count,
    output logic       armed
);

    localparam logic [1:0] C_RED = 2'd0;
    localparam logic [1:0] C_YEL = 2'd1;
    localparam logic [1:0] C_GRN = 2'd2;
    localparam logic [1:0] C_ILL = 2'd3;

    localparam logic [CNT_W-1:0] L_SAT   = '1;
    localparam logic [CNT_W-1:0] L_MIN_Y = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] L_MIN_R = CNT_W'(MIN_ALLRED);

    typedef enum logic [1:0] {
        MON_INIT,
        MON_RUN,
        MON_FAULT
    } state_t;

    state_t           r_state;
    logic [1:0]       r_prev_h;
    logic [1:0]       r_prev_c;
    logic [CNT_W-1:0] r_yel_h;
    logic [CNT_W-1:0] r_yel_c;
    logic [CNT_W-1:0] r_allred;
    logic             r_viol;
    logic [2:0]       r_viol_code;
    logic             r_fault;
    logic [2:0]       r_fault_code;
    logic [7:0]       r_fault_count;
    logic             r_armed;

    logic             w_trans;
    logic             w_ill;
    logic             w_conf;
    logic             w_skip;
    logic             w_bad;
    logic             w_short_y;
    logic             w_short_r;
    logic             w_viol;
    logic [2:0]       w_code;
    logic             w_both_red;
    logic [CNT_W-1:0] w_yel_h_nxt;
    logic [CNT_W-1:0] w_yel_c_nxt;
    logic [CNT_W-1:0] w_allred_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == L_SAT) ? v : v + CNT_W'(1);
    endfunction

    // Transition checks (codes 3-6) rely on prev_* history, which is not valid on the INIT sample.
    always_comb begin
        w_trans    = (r_state != MON_INIT);
        w_ill      = (hwy == C_ILL) || (cntry == C_ILL);
        w_conf     = (hwy != C_RED) && (cntry != C_RED);
        w_skip     = w_trans && (((r_prev_h == C_GRN) && (hwy == C_RED)) ||
                                 ((r_prev_c == C_GRN) && (cntry == C_RED)));
        w_bad      = w_trans && (((r_prev_h == C_RED) && (hwy == C_YEL)) ||
                                 ((r_prev_h == C_YEL) && (hwy == C_GRN)) ||
                                 ((r_prev_c == C_RED) && (cntry == C_YEL)) ||
                                 ((r_prev_c == C_YEL) && (cntry == C_GRN)));
        w_short_y  = w_trans && (((r_prev_h == C_YEL) && (hwy == C_RED) && (r_yel_h < L_MIN_Y)) ||
                                 ((r_prev_c == C_YEL) && (cntry == C_RED) && (r_yel_c < L_MIN_Y)));
        w_short_r  = w_trans && (r_prev_h == C_RED) && (r_prev_c == C_RED) &&
                     ((hwy == C_GRN) || (cntry == C_GRN)) && (r_allred < L_MIN_R);

        if (w_ill)          w_code = 3'd1;
        else if (w_conf)    w_code = 3'd2;
        else if (w_skip)    w_code = 3'd3;
        else if (w_bad)     w_code = 3'd4;
        else if (w_short_y) w_code = 3'd5;
        else if (w_short_r) w_code = 3'd6;
        else                w_code = 3'd0;
        w_viol = (w_code != 3'd0);

        w_both_red = (hwy == C_RED) && (cntry == C_RED);
        if (r_state == MON_INIT) begin
            // Preset to saturation so a road already mid-yellow/all-red at start-up is not penalised.
            w_yel_h_nxt  = (hwy == C_YEL)   ? L_SAT : '0;
            w_yel_c_nxt  = (cntry == C_YEL) ? L_SAT : '0;
            w_allred_nxt = w_both_red       ? L_SAT : '0;
        end else begin
            w_yel_h_nxt  = (hwy == C_YEL)   ? sat_inc(r_yel_h)  : '0;
            w_yel_c_nxt  = (cntry == C_YEL) ? sat_inc(r_yel_c)  : '0;
            w_allred_nxt = w_both_red       ? sat_inc(r_allred) : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state       <= MON_INIT;
            r_prev_h      <= C_RED;
            r_prev_c      <= C_RED;
            r_yel_h       <= '0;
            r_yel_c       <= '0;
            r_allred      <= '0;
            r_viol        <= 1'b0;
            r_viol_code   <= '0;
            r_fault       <= 1'b0;
            r_fault_code  <= '0;
            r_fault_count <= '0;
            r_armed       <= 1'b0;
        end else begin
            r_viol      <= w_viol;
            r_viol_code <= w_code;
            r_armed     <= 1'b1;
            r_prev_h    <= (hwy == C_ILL)   ? C_RED : hwy;
            r_prev_c    <= (cntry == C_ILL) ? C_RED : cntry;
            r_yel_h     <= w_yel_h_nxt;
            r_yel_c     <= w_yel_c_nxt;
            r_allred    <= w_allred_nxt;
            if (w_viol && (r_fault_count != 8'hFF)) begin
                r_fault_count <= r_fault_count + 8'd1;
            end
            if (w_viol && !r_fault) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_code;
            end
            case (r_state)
                MON_INIT:  r_state <= w_viol ? MON_FAULT : MON_RUN;
                MON_RUN:   r_state <= w_viol ? MON_FAULT : MON_RUN;
                MON_FAULT: r_state <= MON_FAULT;
                default:   r_state <= MON_INIT;
            endcase
        end
    end

    assign viol        = r_viol;
    assign viol_code   = r_viol_code;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign fault_count = r_fault_count;
    assign armed       = r_armed;

endmodule

// File: tb/tb_sig_monitor.sv
// Directed-vector bench for sig_monitor: a table of {clear, hwy, cntry, expected outputs}
// records plus hand-written sequences for all-red clearance, clear mid-fault and count saturation.
module tb_sig_monitor;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;
    localparam logic [1:0] X = 2'd3;

    logic       clock;
    logic       clear;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       viol;
    logic [2:0] viol_code;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_count;
    logic       armed;

    int n_checks;
    int n_miss;

    sig_monitor #(
        .MIN_YELLOW (3),
        .MIN_ALLRED (2),
        .CNT_W      (4)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .hwy         (hwy),
        .cntry       (cntry),
        .viol        (viol),
        .viol_code   (viol_code),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_count (fault_count),
        .armed       (armed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       clr;
        logic [1:0] h;
        logic [1:0] c;
        logic       v;
        logic [2:0] vc;
        logic       f;
        logic [2:0] fc;
        logic [7:0] cnt;
        logic       a;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(input logic clr, input logic [1:0] h, input logic [1:0] c,
                               input logic v, input logic [2:0] vc, input logic f,
                               input logic [2:0] fc, input logic [7:0] cnt, input logic a);
        vec_t r;
        r.clr = clr; r.h = h; r.c = c; r.v = v; r.vc = vc;
        r.f = f; r.fc = fc; r.cnt = cnt; r.a = a;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic clr, input logic [1:0] h, input logic [1:0] c);
        @(negedge clock);
        clear = clr;
        hwy   = h;
        cntry = c;
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [2:0] vc, input logic f,
                             input logic [2:0] fc, input logic [7:0] cnt, input logic a);
        cmp({tag, ".viol"},        {7'd0, viol},        {7'd0, v});
        cmp({tag, ".viol_code"},   {5'd0, viol_code},   {5'd0, vc});
        cmp({tag, ".fault"},       {7'd0, fault},       {7'd0, f});
        cmp({tag, ".fault_code"},  {5'd0, fault_code},  {5'd0, fc});
        cmp({tag, ".fault_count"}, fault_count,         cnt);
        cmp({tag, ".armed"},       {7'd0, armed},       {7'd0, a});
    endtask

    task automatic step(input string tag, input logic clr, input logic [1:0] h, input logic [1:0] c,
                        input logic v, input logic [2:0] vc, input logic f,
                        input logic [2:0] fc, input logic [7:0] cnt, input logic a);
        apply(clr, h, c);
        check_all(tag, v, vc, f, fc, cnt, a);
    endtask

    task automatic push_n(input int n, input logic [1:0] h, input logic [1:0] c);
        for (int i = 0; i < n; i++) tbl.push_back(V(1'b0, h, c, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b1));
    endtask

    initial begin
        n_checks = 0;
        n_miss   = 0;
        clear    = 1'b1;
        hwy      = R;
        cntry    = R;

        // Full legal cycle: no violation anywhere, armed from the first sample after clear.
        tbl.push_back(V(1'b1, G, G, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b0));
        push_n(4, G, R);
        push_n(3, Y, R);
        push_n(2, R, R);
        push_n(5, R, G);
        push_n(3, R, Y);
        push_n(2, R, R);
        push_n(1, G, R);
        // Conflict both green, then cntry skips yellow while already faulted.
        tbl.push_back(V(1'b1, R, R, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b0));
        tbl.push_back(V(1'b0, G, R, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b1));
        tbl.push_back(V(1'b0, G, G, 1'b1, 3'd2, 1'b1, 3'd2, 8'd1, 1'b1));
        tbl.push_back(V(1'b0, G, R, 1'b1, 3'd3, 1'b1, 3'd2, 8'd2, 1'b1));
        tbl.push_back(V(1'b0, G, R, 1'b0, 3'd0, 1'b1, 3'd2, 8'd2, 1'b1));
        // Skip-yellow, then legal all-red/green, then a 2-sample yellow (short).
        tbl.push_back(V(1'b1, R, R, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b0));
        tbl.push_back(V(1'b0, G, R, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b1));
        tbl.push_back(V(1'b0, R, R, 1'b1, 3'd3, 1'b1, 3'd3, 8'd1, 1'b1));
        tbl.push_back(V(1'b0, R, R, 1'b0, 3'd0, 1'b1, 3'd3, 8'd1, 1'b1));
        tbl.push_back(V(1'b0, G, R, 1'b0, 3'd0, 1'b1, 3'd3, 8'd1, 1'b1));
        tbl.push_back(V(1'b0, Y, R, 1'b0, 3'd0, 1'b1, 3'd3, 8'd1, 1'b1));
        tbl.push_back(V(1'b0, Y, R, 1'b0, 3'd0, 1'b1, 3'd3, 8'd1, 1'b1));
        tbl.push_back(V(1'b0, R, R, 1'b1, 3'd5, 1'b1, 3'd3, 8'd2, 1'b1));
        // Illegal code together with a conflict: lowest code wins.
        tbl.push_back(V(1'b1, R, R, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b0));
        tbl.push_back(V(1'b0, G, R, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b1));
        tbl.push_back(V(1'b0, X, G, 1'b1, 3'd1, 1'b1, 3'd1, 8'd1, 1'b1));
        tbl.push_back(V(1'b0, R, G, 1'b0, 3'd0, 1'b1, 3'd1, 8'd1, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].clr, tbl[i].h, tbl[i].c, tbl[i].v, tbl[i].vc,
                 tbl[i].f, tbl[i].fc, tbl[i].cnt, tbl[i].a);
        end

        // One all-red sample before cntry green is too short.
        step("ar1.clr", 1'b1, R, R, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b0);
        apply(1'b0, G, R);
        for (int i = 0; i < 3; i++) apply(1'b0, Y, R);
        step("ar1.rr", 1'b0, R, R, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b1);
        step("ar1.rg", 1'b0, R, G, 1'b1, 3'd6, 1'b1, 3'd6, 8'd1, 1'b1);

        // Two all-red samples is exactly enough.
        apply(1'b1, R, R);
        apply(1'b0, G, R);
        for (int i = 0; i < 3; i++) apply(1'b0, Y, R);
        apply(1'b0, R, R);
        apply(1'b0, R, R);
        step("ar2.rg", 1'b0, R, G, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b1);

        // Clear while faulted, resume mid-yellow: no transition fault from pre-clear history.
        apply(1'b1, R, R);
        step("cl.gg", 1'b0, G, G, 1'b1, 3'd2, 1'b1, 3'd2, 8'd1, 1'b1);
        step("cl.clr", 1'b1, G, G, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b0);
        step("cl.init", 1'b0, R, Y, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b1);
        step("cl.y2", 1'b0, R, Y, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b1);
        step("cl.rr", 1'b0, R, R, 1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b1);

        // Continuous conflict: one violation per sample, counter saturates at 255.
        apply(1'b1, R, R);
        for (int i = 0; i < 254; i++) apply(1'b0, G, G);
        cmp("sat.254", fault_count, 8'd254);
        for (int i = 0; i < 6; i++) apply(1'b0, G, G);
        check_all("sat.260", 1'b1, 3'd2, 1'b1, 3'd2, 8'd255, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
